// File: rtl/hex_debug_display_if.sv
// Bus bundle between the board-level debug source and hex_debug_display.
// master = side that supplies page data and user controls,
// slave  = the display block that drives the segment pins and page index.
interface hex_debug_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_PAGES  = 4
);
  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data;
  logic                              page_btn;
  logic                              freeze;
  logic                              blink_en;
  logic [NUM_DIGITS*7-1:0]           hex_n;
  logic [$clog2(NUM_PAGES)-1:0]      page;

  modport master (
    output page_data, page_btn, freeze, blink_en,
    input  hex_n, page
  );

  modport slave (
    input  page_data, page_btn, freeze, blink_en,
    output hex_n, page
  );
endinterface

// File: rtl/hex_debug_display.sv
// hex_debug_display: NUM_DIGITS-digit 7-segment debug display with a
// debounced page-step button, freeze and blink modes.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shown).
module hex_debug_display #(
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_PAGES       = 4,
  parameter int DEBOUNCE_CYCLES = 41_900,
  parameter int BLINK_DIV       = 2_097_152
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_debug_display_if.slave   bus
);

  localparam int DW  = NUM_DIGITS * 4;
  localparam int SW  = NUM_DIGITS * 7;
  localparam int PW  = $clog2(NUM_PAGES);
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BKW-1:0] BK_LAST   = BKW'(BLINK_DIV - 1);
  localparam logic [PW-1:0]  PAGE_LAST = PW'(NUM_PAGES - 1);

  // Active-high segment pattern, bit0 = a .. bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h67;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  logic           btn_s1, btn_s2, btn_db;
  logic [DBW-1:0] db_cnt;
  logic           btn_differ, db_done, adv;
  logic           reload_p0;
  logic [PW-1:0]  page_q;
  logic [DW-1:0]  page_slice;
  logic [DW-1:0]  snap_p0;
  logic [SW-1:0]  seg_n;
  logic [SW-1:0]  hex_p1;
  logic [BKW-1:0] blink_cnt;
  logic           blink_ph;

  assign btn_differ = (btn_s2 != btn_db);
  assign db_done    = btn_differ && (db_cnt == DB_LAST);
  assign adv        = db_done && !btn_s2;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= bus.page_btn;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: accept a new level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (!btn_differ) begin
      db_cnt <= '0;
    end else if (db_done) begin
      btn_db <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end

  // Page stepping with wrap; reload flag forces one snapshot load after a page change.
  always_ff @(posedge clk) begin
    if (rst) begin
      page_q    <= '0;
      reload_p0 <= 1'b0;
    end else begin
      reload_p0 <= adv;
      if (adv) page_q <= (page_q == PAGE_LAST) ? '0 : page_q + PW'(1);
    end
  end

  // Slice of the packed page bus for the current page.
  always_comb begin
    page_slice = bus.page_data[int'(page_q)*DW +: DW];
  end

  // ---- stage p0: snapshot of the selected page ----
  always_ff @(posedge clk) begin
    if (rst)                           snap_p0 <= '0;
    else if (!bus.freeze || reload_p0) snap_p0 <= page_slice;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic keep;
  // Decode with leading-zero blanking, scanning from the top digit down.
  always_comb begin
    seg_n = '1;
    keep  = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      if (snap_p0[d*4 +: 4] != 4'h0 || d == 0) keep = 1'b1;
      seg_n[d*7 +: 7] = keep ? ~seg7(snap_p0[d*4 +: 4]) : 7'h7F;
    end
  end
`else
  // Decode every digit of the snapshot to active-low segments.
  always_comb begin
    seg_n = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      seg_n[d*7 +: 7] = ~seg7(snap_p0[d*4 +: 4]);
    end
  end
`endif

  // Blink timebase: half-period counter and phase, idle while blink is off.
  always_ff @(posedge clk) begin
    if (rst || !bus.blink_en) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BKW'(1);
    end
  end

  // ---- stage p1: registered pins, blanked during the blink-off phase ----
  always_ff @(posedge clk) begin
    if (rst)                            hex_p1 <= '1;
    else if (bus.blink_en && blink_ph)  hex_p1 <= '1;
    else                                hex_p1 <= seg_n;
  end

  assign bus.hex_n = hex_p1;
  assign bus.page  = page_q;

endmodule

// File: tb/tb_hex_debug_display.sv
// Self-checking bench for hex_debug_display (4 digits, 4 pages,
// DEBOUNCE_CYCLES=4, BLINK_DIV=8). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_hex_debug_display;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  hex_debug_display_if #(.NUM_DIGITS(4), .NUM_PAGES(4)) bus ();

  hex_debug_display #(
    .NUM_DIGITS(4), .NUM_PAGES(4), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [27:0] BLANK  = '1;
  localparam logic [27:0] H_ABCD = ~{7'h77, 7'h7C, 7'h39, 7'h5E};
  localparam logic [27:0] H_2233 = ~{7'h5B, 7'h5B, 7'h4F, 7'h4F};
  localparam logic [27:0] H_5678 = ~{7'h6D, 7'h7D, 7'h07, 7'h7F};
  localparam logic [27:0] H_9999 = ~{7'h67, 7'h67, 7'h67, 7'h67};
  localparam logic [27:0] H_1234 = ~{7'h06, 7'h5B, 7'h4F, 7'h66};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] H_0011 = ~{7'h00, 7'h00, 7'h06, 7'h06};
`else
  localparam logic [27:0] H_0011 = ~{7'h3F, 7'h3F, 7'h06, 7'h06};
`endif

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [27:0] exp;
    logic [27:0] exp_lz;
  } vec_t;

  vec_t vecs[8];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clean press: checks the exact advance cycle and that release does not advance.
  task automatic press(input logic [1:0] prev_pg, input logic [1:0] exp_pg, input string nm);
    bus.page_btn = 1'b0;
    step(5);
    chk({nm, "_before_adv"}, 32'(bus.page), 32'(prev_pg));
    step(1);
    chk({nm, "_adv"}, 32'(bus.page), 32'(exp_pg));
    step(2);
    bus.page_btn = 1'b1;
    step(8);
    chk({nm, "_after_release"}, 32'(bus.page), 32'(exp_pg));
  endtask

  initial begin
    logic [27:0] e;
    logic [1:0]  seq_pg[6];

    vecs[0] = '{"dec_0123", 16'h0123, ~{7'h3F, 7'h06, 7'h5B, 7'h4F}, ~{7'h00, 7'h06, 7'h5B, 7'h4F}};
    vecs[1] = '{"dec_4567", 16'h4567, ~{7'h66, 7'h6D, 7'h7D, 7'h07}, ~{7'h66, 7'h6D, 7'h7D, 7'h07}};
    vecs[2] = '{"dec_89AB", 16'h89AB, ~{7'h7F, 7'h67, 7'h77, 7'h7C}, ~{7'h7F, 7'h67, 7'h77, 7'h7C}};
    vecs[3] = '{"dec_CDEF", 16'hCDEF, ~{7'h39, 7'h5E, 7'h79, 7'h71}, ~{7'h39, 7'h5E, 7'h79, 7'h71}};
    vecs[4] = '{"dec_0000", 16'h0000, ~{7'h3F, 7'h3F, 7'h3F, 7'h3F}, ~{7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[5] = '{"dec_0A00", 16'h0A00, ~{7'h3F, 7'h77, 7'h3F, 7'h3F}, ~{7'h00, 7'h77, 7'h3F, 7'h3F}};
    vecs[6] = '{"dec_00A0", 16'h00A0, ~{7'h3F, 7'h3F, 7'h77, 7'h3F}, ~{7'h00, 7'h00, 7'h77, 7'h3F}};
    vecs[7] = '{"dec_FFFF", 16'hFFFF, ~{7'h71, 7'h71, 7'h71, 7'h71}, ~{7'h71, 7'h71, 7'h71, 7'h71}};

    // Reset state and first display
    rst           = 1'b1;
    bus.page_data = {16'h4455, 16'h2233, 16'h0011, 16'hABCD};
    bus.page_btn  = 1'b1;
    bus.freeze    = 1'b0;
    bus.blink_en  = 1'b0;
    step(3);
    chk("reset_hex", 32'(bus.hex_n), 32'(BLANK));
    chk("reset_page", 32'(bus.page), 32'd0);
    rst = 1'b0;
    step(2);
    chk("first_abcd", 32'(bus.hex_n), 32'(H_ABCD));
    chk("first_page", 32'(bus.page), 32'd0);

    // Decode table on page 0
    for (int i = 0; i < 8; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      e = vecs[i].exp_lz;
`else
      e = vecs[i].exp;
`endif
      bus.page_data[15:0] = vecs[i].data;
      step(1);
      if (i == 0) chk("latency_1cyc_old", 32'(bus.hex_n), 32'(H_ABCD));
      step(1);
      chk(vecs[i].name, 32'(bus.hex_n), 32'(e));
    end
    bus.page_data[15:0] = 16'hABCD;
    step(2);

    // Clean press held 20 cycles
    bus.page_btn = 1'b0;
    step(5);
    chk("clean_no_adv_yet", 32'(bus.page), 32'd0);
    step(1);
    chk("clean_adv_6cyc", 32'(bus.page), 32'd1);
    step(2);
    chk("clean_show_0011", 32'(bus.hex_n), 32'(H_0011));
    step(12);
    chk("clean_single_adv", 32'(bus.page), 32'd1);
    bus.page_btn = 1'b1;
    step(10);
    chk("clean_release_no_adv", 32'(bus.page), 32'd1);

    // Bouncing press, then stable low
    for (int b = 0; b < 4; b++) begin
      bus.page_btn = b[0];
      step(2);
    end
    chk("bounce_no_adv", 32'(bus.page), 32'd1);
    bus.page_btn = 1'b0;
    step(5);
    chk("bounce_stable_pre", 32'(bus.page), 32'd1);
    step(1);
    chk("bounce_stable_adv", 32'(bus.page), 32'd2);
    step(2);
    bus.page_btn = 1'b1;
    step(8);

    // Presses through the wrap
    seq_pg[0] = 2'd3; seq_pg[1] = 2'd0; seq_pg[2] = 2'd1;
    seq_pg[3] = 2'd2; seq_pg[4] = 2'd3; seq_pg[5] = 2'd0;
    for (int p = 0; p < 6; p++) begin
      press((p == 0) ? 2'd2 : seq_pg[p-1], seq_pg[p], $sformatf("wrap%0d", p));
    end

    // Freeze holds page 0 display; page change reloads once
    bus.freeze = 1'b1;
    bus.page_data[15:0] = 16'h1234;
    step(4);
    chk("freeze_hold_abcd", 32'(bus.hex_n), 32'(H_ABCD));
    press(2'd0, 2'd1, "freeze_press");
    chk("freeze_new_page", 32'(bus.hex_n), 32'(H_0011));
    bus.page_data[31:16] = 16'h5678;
    step(4);
    chk("freeze_ignore_data", 32'(bus.hex_n), 32'(H_0011));
    bus.freeze = 1'b0;
    step(2);
    chk("unfreeze_5678", 32'(bus.hex_n), 32'(H_5678));

    // Freeze rising in the same cycle as the advance
    bus.page_btn = 1'b0;
    step(5);
    bus.freeze = 1'b1;
    step(1);
    chk("adv_freeze_page", 32'(bus.page), 32'd2);
    step(2);
    chk("adv_freeze_reload", 32'(bus.hex_n), 32'(H_2233));
    bus.page_btn = 1'b1;
    bus.page_data[47:32] = 16'h9999;
    step(8);
    chk("adv_freeze_hold", 32'(bus.hex_n), 32'(H_2233));
    bus.freeze = 1'b0;
    step(2);
    chk("adv_freeze_release", 32'(bus.hex_n), 32'(H_9999));

    // Blink: 8 visible, 8 blank, 8 visible
    bus.blink_en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step(1);
      chk($sformatf("blink_c%0d", i), 32'(bus.hex_n),
          32'((i >= 9 && i <= 16) ? BLANK : H_9999));
    end
    step(4);
    chk("blink_second_blank", 32'(bus.hex_n), 32'(BLANK));
    bus.blink_en = 1'b0;
    step(1);
    chk("blink_off_visible", 32'(bus.hex_n), 32'(H_9999));

    // Reset mid-debounce and mid-blink
    bus.blink_en = 1'b1;
    step(10);
    chk("pre_reset_blank", 32'(bus.hex_n), 32'(BLANK));
    bus.page_btn = 1'b0;
    step(4);
    rst = 1'b1;
    bus.page_btn = 1'b1;
    step(2);
    chk("rst2_hex", 32'(bus.hex_n), 32'(BLANK));
    chk("rst2_page", 32'(bus.page), 32'd0);
    rst = 1'b0;
    step(2);
    chk("rst2_vis_c2", 32'(bus.hex_n), 32'(H_1234));
    step(6);
    chk("rst2_vis_c8", 32'(bus.hex_n), 32'(H_1234));
    step(1);
    chk("rst2_blank_c9", 32'(bus.hex_n), 32'(BLANK));
    step(10);
    chk("rst2_no_adv", 32'(bus.page), 32'd0);
    bus.blink_en = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
